// File: rtl/simon_ctrl_pkg.sv
// simon_pkg: shared types and constants for the Simon Says controller.
// Holds the FSM state encoding, round width, speed ceiling and speed helper.
package simon_pkg;

  localparam int ROUND_W = 5;
  localparam logic [2:0] SPEED_MAX = 3'd7;

  typedef enum logic [3:0] {
    IDLE,
    SEED,
    ROUND_INIT,
    LOAD,
    FLASH_ON,
    FLASH_OFF,
    PLAY_INIT,
    PLAY_LOAD,
    PLAY_WAIT,
    NEXT,
    WIN,
    LOSE
  } state_t;

  // Speed for the upcoming round, given the round just finished.
  // (new_round - 1) / step == old_round / step.
  function automatic logic [2:0] speed_calc(
    input logic [ROUND_W-1:0] rnd,
    input int unsigned        step
  );
    int unsigned q;
    q = 32'(rnd) / step;
    return (q > 32'd7) ? SPEED_MAX : 3'(q);
  endfunction

endpackage

// File: rtl/simon_ctrl_if.sv
// fsm_sig: command/status bundle between the controller and board blocks.
// fsm modport: controller side; board modport: rng/reg8/flasher/check side.
interface fsm_sig;
  import simon_pkg::*;

  logic               go;
  logic               btn_valid;
  logic               result;
  logic               empty;
  logic               pulse;

  logic               start;
  logic               rst_seedgen;
  logic               load_colour;
  logic               load_speed;
  logic [2:0]         speed;
  logic               flash_colour;
  logic               player_turn;
  logic [ROUND_W-1:0] check_round;
  logic               win;
  logic               lose;

  modport fsm (
    input  go, btn_valid, result, empty, pulse,
    output start, rst_seedgen, load_colour, load_speed, speed,
    output flash_colour, player_turn, check_round, win, lose
  );

  modport board (
    output go, btn_valid, result, empty, pulse,
    input  start, rst_seedgen, load_colour, load_speed, speed,
    input  flash_colour, player_turn, check_round, win, lose
  );

endinterface

// File: rtl/simon_ctrl.sv
// simon_ctrl: Simon Says round controller (replay sequence, then player turn).
// Ports: clk, reset_n (async low), bus (fsm_sig.fsm: go/btn/pulse in, commands out).
module simon_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_ROUNDS = 16,
  parameter int SPEED_STEP = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  fsm_sig.fsm    bus
);

  localparam logic [ROUND_W-1:0] LP_MAX = ROUND_W'(MAX_ROUNDS);

  state_t             r_state;
  state_t             w_next;
  logic [ROUND_W-1:0] r_round;
  logic [ROUND_W-1:0] r_idx;
  logic [ROUND_W-1:0] w_idx_inc;
  logic [2:0]         r_speed;
  logic               r_armed;

  logic r_start, r_rst_seed, r_load_col, r_load_spd;
  logic r_flash, r_turn, r_win, r_lose;

  assign w_idx_inc = r_idx + 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (bus.go) w_next = SEED;
      SEED:       w_next = ROUND_INIT;
      ROUND_INIT: w_next = LOAD;
      LOAD:       w_next = FLASH_ON;
      // r_armed is low on the entry cycle so a
      // coincident pulse cannot cut the dwell short
      FLASH_ON:   if (bus.pulse && r_armed) w_next = FLASH_OFF;
      FLASH_OFF: begin
        if (bus.pulse)
          w_next = (w_idx_inc == r_round) ? PLAY_INIT : LOAD;
      end
      PLAY_INIT:  w_next = PLAY_LOAD;
      PLAY_LOAD:  w_next = PLAY_WAIT;
      PLAY_WAIT: begin
        if (bus.btn_valid) begin
          unique case (1'b1)
            !bus.result:              w_next = LOSE;
            bus.result && !bus.empty: w_next = PLAY_LOAD;
            bus.result && bus.empty:  w_next = NEXT;
            default:                  w_next = LOSE;
          endcase
        end
      end
      NEXT:       w_next = (r_round == LP_MAX) ? WIN : ROUND_INIT;
      WIN:        if (bus.go) w_next = SEED;
      LOSE:       if (bus.go) w_next = SEED;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_round <= '0;
      r_idx   <= '0;
      r_speed <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= (r_state == FLASH_ON);
      if (w_next == SEED) begin
        r_round <= ROUND_W'(1);
        r_speed <= '0;
      end
      if (r_state == ROUND_INIT)
        r_idx <= '0;
      if (r_state == FLASH_OFF && bus.pulse)
        r_idx <= w_idx_inc;
      if (r_state == NEXT && r_round != LP_MAX) begin
        r_round <= r_round + 1'b1;
        r_speed <= speed_calc(r_round, SPEED_STEP);
      end
    end
  end

  // Outputs decoded from the next state so each one
  // is high for exactly the cycles spent in its state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start    <= 1'b0;
      r_rst_seed <= 1'b0;
      r_load_col <= 1'b0;
      r_load_spd <= 1'b0;
      r_flash    <= 1'b0;
      r_turn     <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      r_start    <= (w_next == SEED);
      r_rst_seed <= (w_next == ROUND_INIT) || (w_next == PLAY_INIT);
      r_load_col <= (w_next == LOAD) || (w_next == PLAY_LOAD);
      r_load_spd <= (w_next == ROUND_INIT);
      r_flash    <= (w_next == FLASH_ON);
      r_turn     <= (w_next == PLAY_WAIT);
      r_win      <= (w_next == WIN);
      r_lose     <= (w_next == LOSE);
    end
  end

  assign bus.start        = r_start;
  assign bus.rst_seedgen  = r_rst_seed;
  assign bus.load_colour  = r_load_col;
  assign bus.load_speed   = r_load_spd;
  assign bus.speed        = r_speed;
  assign bus.flash_colour = r_flash;
  assign bus.player_turn  = r_turn;
  assign bus.check_round  = r_round;
  assign bus.win          = r_win;
  assign bus.lose         = r_lose;

endmodule

// File: tb/tb_simon_ctrl.sv
// tb_simon_ctrl: directed bench for simon_ctrl.
// Three instances share stimulus: default, (2 rounds, step 1), (16 rounds, step 1).
module tb_simon_ctrl;
  import simon_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   pc = 0;

  always #5 clk = ~clk;

  fsm_sig bus_a ();
  fsm_sig bus_b ();
  fsm_sig bus_c ();

  assign bus_b.go        = bus_a.go;
  assign bus_b.btn_valid = bus_a.btn_valid;
  assign bus_b.result    = bus_a.result;
  assign bus_b.empty     = bus_a.empty;
  assign bus_b.pulse     = bus_a.pulse;
  assign bus_c.go        = bus_a.go;
  assign bus_c.btn_valid = bus_a.btn_valid;
  assign bus_c.result    = bus_a.result;
  assign bus_c.empty     = bus_a.empty;
  assign bus_c.pulse     = bus_a.pulse;

  simon_ctrl u_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.fsm)
  );
  simon_ctrl #(.MAX_ROUNDS(2), .SPEED_STEP(1)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.fsm)
  );
  simon_ctrl #(.MAX_ROUNDS(16), .SPEED_STEP(1)) u_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c.fsm)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_flags"}, 32'({bus_a.start, bus_a.rst_seedgen,
        bus_a.load_colour, bus_a.load_speed, bus_a.flash_colour,
        bus_a.player_turn, bus_a.win, bus_a.lose}), 32'd0);
    chk({tag, "_round"}, 32'(bus_a.check_round), 32'd0);
    chk({tag, "_speed"}, 32'(bus_a.speed), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus_a.go = 1'b0;
    bus_a.pulse = 1'b0;
    bus_a.btn_valid = 1'b0;
  endtask

  task automatic tickp();
    bus_a.pulse = (pc % 4 == 3);
    pc++;
    step();
  endtask

  task automatic press(input logic res, input logic emp);
    bus_a.btn_valid = 1'b1;
    bus_a.result = res;
    bus_a.empty = emp;
    step();
  endtask

  // Entered from ROUND_INIT; runs to PLAY_WAIT, counting replayed colours.
  task automatic replay(input int r, input string tag);
    int  loads;
    bit  seen;
    loads = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !bus_a.player_turn; k++) begin
      tickp();
      if (bus_a.load_colour && !seen) loads++;
      if (bus_a.rst_seedgen && !bus_a.load_speed) seen = 1'b1;
    end
    chk({tag, "_loads"}, 32'(loads), 32'(r));
    chk({tag, "_turn"}, 32'(bus_a.player_turn), 32'd1);
    chk({tag, "_round"}, 32'(bus_a.check_round), 32'(r));
  endtask

  task automatic play_ok(input int r);
    for (int p = 1; p < r; p++) begin
      press(1'b1, 1'b0);
      step();
    end
    press(1'b1, 1'b1);
    step();
  endtask

  initial begin
    bus_a.go = 1'b0;
    bus_a.btn_valid = 1'b0;
    bus_a.result = 1'b0;
    bus_a.empty = 1'b0;
    bus_a.pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst");
    reset_n = 1'b1;
    step();
    chk_idle("idle");
    press(1'b1, 1'b1);
    chk_idle("idle_btn");

    bus_a.go = 1'b1;
    step();
    chk("seed_start", 32'(bus_a.start), 32'd1);
    chk("seed_round", 32'(bus_a.check_round), 32'd1);
    step();
    chk("ri_flags", 32'({bus_a.rst_seedgen, bus_a.load_speed, bus_a.start}), 32'b110);
    chk("ri_speed", 32'(bus_a.speed), 32'd0);
    step();
    chk("load", 32'({bus_a.load_colour, bus_a.rst_seedgen}), 32'b10);
    step();
    chk("fon", 32'(bus_a.flash_colour), 32'd1);
    bus_a.pulse = 1'b1;
    step();
    chk("fon_entry_pulse", 32'(bus_a.flash_colour), 32'd1);
    step();
    step();
    chk("fon_hold", 32'(bus_a.flash_colour), 32'd1);
    bus_a.pulse = 1'b1;
    bus_a.btn_valid = 1'b1;
    bus_a.result = 1'b0;
    step();
    chk("foff", 32'({bus_a.flash_colour, bus_a.lose}), 32'd0);
    step();
    step();
    step();
    bus_a.pulse = 1'b1;
    step();
    chk("pinit", 32'({bus_a.rst_seedgen, bus_a.load_speed}), 32'b10);
    step();
    chk("pload", 32'(bus_a.load_colour), 32'd1);
    step();
    chk("pwait", 32'({bus_a.player_turn, 3'(bus_a.check_round)}), 32'b1001);
    bus_a.pulse = 1'b1;
    step();
    chk("pwait_pulse", 32'(bus_a.player_turn), 32'd1);
    press(1'b1, 1'b1);
    chk("next", 32'({bus_a.player_turn, 3'(bus_a.check_round)}), 32'b0001);
    step();
    chk("r2_round", 32'(bus_a.check_round), 32'd2);
    chk("r2_ldspd", 32'(bus_a.load_speed), 32'd1);
    chk("r2_spd_a", 32'(bus_a.speed), 32'd0);
    chk("r2_spd_b", 32'(bus_b.speed), 32'd1);
    chk("r2_spd_c", 32'(bus_c.speed), 32'd1);

    replay(2, "r2");
    press(1'b1, 1'b0);
    chk("r2_reload", 32'(bus_a.load_colour), 32'd1);
    step();
    chk("r2_wait2", 32'(bus_a.player_turn), 32'd1);
    press(1'b1, 1'b1);
    chk("b_next_nowin", 32'(bus_b.win), 32'd0);
    step();
    chk("r3_round", 32'(bus_a.check_round), 32'd3);
    chk("b_win", 32'(bus_b.win), 32'd1);
    chk("b_win_state", 32'({3'(bus_b.check_round), bus_b.speed}), 32'b010001);

    replay(3, "r3");
    chk("b_win_hold", 32'({bus_b.win, bus_b.load_colour, bus_b.player_turn}), 32'b100);
    chk("b_win_round", 32'(bus_b.check_round), 32'd2);
    press(1'b1, 1'b0);
    step();
    press(1'b0, 1'b0);
    chk("lose", 32'({bus_a.lose, bus_a.player_turn}), 32'b10);
    chk("lose_round", 32'(bus_a.check_round), 32'd3);
    step();
    press(1'b1, 1'b1);
    chk("lose_hold", 32'({bus_a.lose, 3'(bus_a.check_round)}), 32'b1011);
    chk("b_win_stray", 32'(bus_b.win), 32'd1);

    bus_a.go = 1'b1;
    step();
    chk("restart", 32'({bus_a.lose, bus_a.start, 3'(bus_a.check_round)}), 32'b01001);
    chk("b_restart", 32'({bus_b.win, bus_b.start}), 32'b01);
    step();

    for (int r = 1; r <= 16; r++) begin
      replay(r, "g");
      play_ok(r);
      if (r == 4) begin
        chk("g5_spd_a", 32'(bus_a.speed), 32'd1);
        chk("g5_spd_c", 32'(bus_c.speed), 32'd4);
      end
      if (r == 7) chk("g8_spd_c", 32'(bus_c.speed), 32'd7);
      if (r == 8) chk("g9_spd_c", 32'(bus_c.speed), 32'd7);
      if (r == 15) begin
        chk("g16_round", 32'(bus_a.check_round), 32'd16);
        chk("g16_spd_a", 32'(bus_a.speed), 32'd3);
        chk("g16_spd_c", 32'(bus_c.speed), 32'd7);
      end
    end
    chk("win_a", 32'({bus_a.win, bus_a.lose}), 32'b10);
    chk("win_round", 32'(bus_a.check_round), 32'd16);
    chk("win_speed", 32'(bus_a.speed), 32'd3);
    step();
    chk("win_held", 32'(bus_a.win), 32'd1);

    bus_a.go = 1'b1;
    step();
    step();
    replay(1, "h1");
    play_ok(1);
    for (int k = 0; k < 10 && !bus_a.flash_colour; k++) tickp();
    chk("h2_flash", 32'(bus_a.flash_colour), 32'd1);
    chk("h2_round", 32'(bus_a.check_round), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    step();
    chk_idle("post_rst");
    bus_a.go = 1'b1;
    step();
    chk("rst_go", 32'({bus_a.start, 3'(bus_a.check_round)}), 32'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_ctrl.md
Name: simon_ctrl

Overview:
- Top-level game controller FSM for Simon Says. It drives the fsm_sig command signals and consumes result, empty and pulse.
- It runs one round at a time:
  - replays the colour sequence from the seed register and flashes each colour for one pulse period;
  - then hands control to the player and advances the round on success.
- It sits between the board inputs (start button, colour buttons) and the reg8, rng_in, segments, flasher, led and check blocks.

Parameters:
- MAX_ROUNDS, 16, rounds needed to win; legal range 1..31, fits check_round.
- SPEED_STEP, 4, rounds per speed increment; speed saturates at 7.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- go  input  1  one-cycle synchronised start-button pulse.
- btn_valid  input  1  one-cycle pulse; player pressed a colour button.
- result  input  1  from check; pressed colour matches expected; valid when btn_valid=1.
- empty  input  1  from check; no expected entries remain this round; valid when btn_valid=1.
- pulse  input  1  from flasher; one-cycle tick at the loaded speed.
- start  output  1  one-cycle; rng_in captures a new game seed.
- rst_seedgen  output  1  one-cycle; reg8 rewinds the sequence to the seed.
- load_colour  output  1  one-cycle; segments/reg8 advance to the next colour.
- load_speed  output  1  one-cycle; flasher latches speed.
- speed  output  3  flasher speed code.
- flash_colour  output  1  led shows the current colour while high.
- player_turn  output  1  high while awaiting player input.
- check_round  output  5  current round number, 1..MAX_ROUNDS; 0 in IDLE.
- win  output  1  held high in WIN.
- lose  output  1  held high in LOSE.

Behaviour:
- Outputs are registered Moore outputs: every output is asserted for exactly the cycles the FSM occupies the corresponding state.
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0; check_round=0; speed=0; idx=0.
  - Reset mid-game aborts immediately.
- IDLE: on go, go to SEED.
- SEED: start=1 for one cycle. Set check_round=1, speed=0. Go to ROUND_INIT.
- ROUND_INIT: rst_seedgen=1 and load_speed=1 for one cycle; idx=0. Go to LOAD.
- LOAD: load_colour=1 for one cycle. Go to FLASH_ON.
- FLASH_ON:
  - flash_colour=1.
  - Wait for pulse, then go to FLASH_OFF.
  - A pulse present on the entry cycle is ignored; dwell is always at least one full period.
- FLASH_OFF:
  - flash_colour=0; wait for pulse.
  - On pulse, idx=idx+1 (5 bits).
  - If the new idx equals check_round, go to PLAY_INIT; otherwise go to LOAD.
- PLAY_INIT: rst_seedgen=1 for one cycle. Go to PLAY_LOAD.
- PLAY_LOAD: load_colour=1 for one cycle. Go to PLAY_WAIT.
- PLAY_WAIT:
  - player_turn=1.
  - On btn_valid, sample result and empty in that same cycle:
    - result=0: go to LOSE.
    - result=1 and empty=0: go to PLAY_LOAD.
    - result=1 and empty=1: round complete, go to NEXT.
  - btn_valid outside PLAY_WAIT is ignored.
- NEXT (one cycle):
  - If check_round==MAX_ROUNDS, go to WIN.
  - Otherwise check_round=check_round+1.
  - speed=min(check_round_new-1)/SPEED_STEP, saturated at 7. Integer divide; widen to 6 bits before saturating.
  - Go to ROUND_INIT.
- WIN / LOSE:
  - win or lose held at 1; check_round and speed hold their values.
  - go goes to SEED; win/lose clear on that transition.
- Simultaneous events:
  - go is ignored in every state except IDLE, WIN and LOSE.
  - pulse and btn_valid in the same cycle: only the input relevant to the current state is acted on.
- No state is unreachable. Unused state encodings go to IDLE.
- Latency from go to the first load_colour is 3 cycles: SEED, ROUND_INIT, LOAD.

Decomposition:
- Package simon_pkg holds:
  - state_t enum: IDLE, SEED, ROUND_INIT, LOAD, FLASH_ON, FLASH_OFF, PLAY_INIT, PLAY_LOAD, PLAY_WAIT, NEXT, WIN, LOSE.
  - SPEED_MAX=3'd7.
  - ROUND_W=5.
- Single module, no sub-module.
- The top-level connects outputs through the fsm_sig.fsm modport.

Test Plan:
- Reset, then go; drive pulse every 4 cycles. Expected: start pulse, then rst_seedgen with load_speed (speed=0), then one load_colour. flash_colour lasts exactly until the next pulse; player_turn is asserted with check_round=1.
- Round 1, btn_valid with result=1, empty=1. Expected: NEXT, check_round=2, round 2 flashes exactly 2 colours (2 load_colour pulses before PLAY_INIT).
- In round 3, first press with result=1, empty=0, second press with result=0. Expected: lose=1, player_turn=0, check_round holds 3; a later go restarts at check_round=1.
- MAX_ROUNDS=2, SPEED_STEP=1; play both rounds correctly. Expected: speed=1 at round 2, then win=1 held. A stray btn_valid or pulse in WIN has no effect.
- Default parameters; play through round 16. Expected: speed=3 at round 16 (15/4). With SPEED_STEP=1, speed saturates at 7 from round 8 onward.
- Assert reset_n=0 during FLASH_ON of round 2. Expected: all outputs 0 asynchronously; FSM in IDLE; go is required to restart.
